// File: rtl/imem_loader_if.sv
// +----------------------------------------------------------------------+
// | imem_loader_if : byte-stream, RAM write port and load control bundle |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface imem_loader_if #(
  parameter int AW = 8
);
  logic          load_en;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          overflow;

  // master is the loader itself; slave is the stream source / RAM / core side
  modport master (
    input  load_en, in_valid, in_data,
    output in_ready, we, waddr, wdata, cpu_reset, busy, done, overflow
  );

  modport slave (
    output load_en, in_valid, in_data,
    input  in_ready, we, waddr, wdata, cpu_reset, busy, done, overflow
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------+
// | imem_loader : assembles a length-prefixed LE byte stream into 32-bit |
// | instruction RAM writes, holding the core in reset during the load.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  imem_loader_if.master bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q;
  logic [15:0] len_q;
  logic [15:0] widx_q;
  logic [1:0]  bcnt_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic        ovf_q;

  logic        in_load;
  logic        in_range;
  logic [15:0] widx_inc;

  assign in_load  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_WRITE);
  assign in_range = ({16'd0, widx_q} < DEPTH_W);
  assign widx_inc = widx_q + 16'd1;

  assign bus.in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                         (state_q == S_DATA);
  // load_en gating lets an abort landing in WRITE suppress the pending write
  assign bus.we        = (state_q == S_WRITE) && bus.load_en && in_range;
  assign bus.waddr     = widx_q[AW-1:0];
  assign bus.wdata     = wdata_q;
  assign bus.cpu_reset = in_load;
  assign bus.busy      = in_load;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      widx_q  <= 16'd0;
      bcnt_q  <= 2'd0;
      wdata_q <= 32'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.load_en) begin
            state_q <= S_LEN_LO;
            len_q   <= 16'd0;
            widx_q  <= 16'd0;
            bcnt_q  <= 2'd0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end

        S_LEN_LO: begin
          if (!bus.load_en) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else if (bus.in_valid) begin
            len_q[7:0] <= bus.in_data;
            state_q    <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (!bus.load_en) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else if (bus.in_valid) begin
            len_q[15:8] <= bus.in_data;
            if ({bus.in_data, len_q[7:0]} == 16'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (!bus.load_en) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else if (bus.in_valid) begin
            wdata_q[{bcnt_q, 3'b000} +: 8] <= bus.in_data;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_q <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (!bus.load_en) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            if (!in_range) begin
              ovf_q <= 1'b1;
            end
            widx_q <= widx_inc;
            if (widx_inc == len_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DONE: begin
          if (!bus.load_en) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
